segre_if_fetch_queue: RTL
=========================

Name: segre_if_fetch_queue

Overview:
Parametrised successor instruction-fetch stage for the Segre core. It drives the I-cache tag/data lookup and buffers hit instructions in a FQ_DEPTH-entry fetch queue, decoupling fetch from decode stalls. Miss handling is an FSM with an MMU refill handshake. Branch handling is selectable: stall-on-branch, or sequential predict-not-taken with flush on redirect. It sits between the I-cache/MMU and the ID stage.

Parameters:
ADDR_SIZE, 32, fetch address width
WORD_SIZE, 32, instruction width
FQ_DEPTH, 4, fetch-queue entries; power of 2, >=2
BRANCH_STALL, 1, 1 = stop fetching after a branch/jal/jalr until resolved; 0 = keep fetching pc+4
RESET_PC, 0, first fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
ic_req_o  out  1  I-cache lookup request this cycle
ic_addr_o  out  ADDR_SIZE  lookup address (fetch_pc)
ic_hit_i  in  1  same-cycle hit for ic_addr_o
ic_miss_i  in  1  same-cycle miss for ic_addr_o
ic_data_i  in  WORD_SIZE  instruction, valid with ic_hit_i
miss_req_o  out  1  one-cycle refill request to MMU
miss_addr_o  out  ADDR_SIZE  missing address, held until refill
refill_done_i  in  1  MMU refill complete pulse
instr_valid_o  out  1  queue head valid
instr_o  out  WORD_SIZE  queue head instruction; NOP when empty
pc_o  out  ADDR_SIZE  queue head pc
id_ready_i  in  1  ID accepts head this cycle
redirect_i  in  1  taken branch / flush from WB
redirect_pc_i  in  ADDR_SIZE  new fetch pc
branch_done_i  in  1  non-taken branch resolved
fq_count_o  out  log2(FQ_DEPTH)+1  queue occupancy

Behaviour:
- Reset (async, rst_i=1): fetch_pc=RESET_PC, state=FETCH, queue empty, fq_count_o=0, instr_valid_o=0, instr_o=NOP, pc_o=0, miss_req_o=0, miss_addr_o=0.
- States FETCH, MISS, BR_WAIT. BR_WAIT is unreachable when BRANCH_STALL=0.
- FETCH:
  - ic_req_o=1 iff fq_count<FQ_DEPTH and !redirect_i.
  - On hit: push {fetch_pc, ic_data_i}; fetch_pc+=4, wrapping mod 2^ADDR_SIZE.
  - If the pushed opcode is OPCODE_BRANCH/JAL/JALR and BRANCH_STALL=1: push it, hold fetch_pc at branch pc+4, go to BR_WAIT.
  - On miss: no push; miss_req_o=1 next cycle for exactly one cycle; miss_addr_o<=fetch_pc; go to MISS.
- MISS: ic_req_o=0. On refill_done_i, go to FETCH and retry the same fetch_pc. miss_addr_o stays stable throughout MISS.
- BR_WAIT: ic_req_o=0. On branch_done_i or redirect_i, go to FETCH.
- Queue timing: a hit in cycle t is visible at instr_o/pc_o in cycle t+1. Pop when instr_valid_o && id_ready_i. Simultaneous push+pop keeps the count. No push when full, even with a same-cycle pop.
- Redirect (highest priority):
  - Flush the queue: count=0 next cycle, instr_valid_o=0. Suppress any same-cycle push or pop.
  - fetch_pc<=redirect_pc_i with bits [1:0] forced to 00.
  - From FETCH or BR_WAIT, go to FETCH.
  - From MISS, stay in MISS until refill_done_i, then fetch from the new pc. No second miss_req_o is issued for the old address.
- redirect_i and branch_done_i in the same cycle: redirect wins.
- refill_done_i outside MISS is ignored.
- ic_hit_i and ic_miss_i are never both 1; if they are, miss takes priority.
- Pointers are log2(FQ_DEPTH) bits and wrap naturally; occupancy is derived from a separate counter.

Decomposition:
- segre_pkg gains: if_fq_state_e {IF_FQ_FETCH, IF_FQ_MISS, IF_FQ_BR_WAIT} and typedef fq_entry_t {pc, instr}.
- segre_pkg already provides OPCODE_BRANCH/JAL/JALR and NOP; reuse them.
- One sub-module: segre_fetch_fifo, a parametrised synchronous FIFO with push/pop/flush, full/empty and count.

Test Plan:
- Reset then constant hits, id_ready_i=1: pc_o sequence 0,4,8,12 starting cycle 1; instr_valid_o stays 1.
- id_ready_i=0 with hits, FQ_DEPTH=4: fq_count_o reaches 4; ic_req_o drops to 0; fetch_pc stays 0x10; release drains 0,4,8,12 in order.
- Miss at 0x8: miss_req_o pulses once with miss_addr_o=0x8; no ic_req_o until refill_done_i 5 cycles later; the next pushed pc is 0x8.
- Redirect to 0x103 while queue holds 3 entries and a same-cycle hit: queue empties; the next fetch is 0x100; the hit entry is never output.
- BRANCH_STALL=1, beq fetched at 0x4: no further requests until branch_done_i; fetch resumes at 0x8. With BRANCH_STALL=0, fetch continues at 0x8 immediately.
- Redirect during MISS on 0x20 to 0x40: no new miss_req_o; after refill_done_i the first lookup address is 0x40.

Source files
------------

// File: rtl/segre_pkg.sv
// segre_pkg: shared RISC-V opcodes, NOP encoding and fetch-stage types
package segre_pkg;

  localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;
  localparam logic [31:0] NOP           = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_FQ_FETCH,
    IF_FQ_MISS,
    IF_FQ_BR_WAIT
  } if_fq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  function automatic logic is_cf(input logic [6:0] op);
    return op inside {OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR};
  endfunction

endpackage

// File: rtl/segre_fetch_fifo.sv
// segre_fetch_fifo: synchronous FIFO with flush, full/empty and occupancy count
module segre_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             push_ok, pop_ok;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign rdata   = mem[rp];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk_i)
    if (push_ok) mem[wp] <= wdata;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end

endmodule

// File: rtl/segre_if_fetch_queue.sv
// segre_if_fetch_queue: I-cache fetch stage with miss FSM, branch stall and fetch queue
module segre_if_fetch_queue
  import segre_pkg::*;
#(
  parameter int unsigned          ADDR_SIZE    = 32,
  parameter int unsigned          WORD_SIZE    = 32,
  parameter int unsigned          FQ_DEPTH     = 4,
  parameter bit                   BRANCH_STALL = 1'b1,
  parameter logic [ADDR_SIZE-1:0] RESET_PC     = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        ic_req_o,
  output logic [ADDR_SIZE-1:0]        ic_addr_o,
  input  logic                        ic_hit_i,
  input  logic                        ic_miss_i,
  input  logic [WORD_SIZE-1:0]        ic_data_i,
  output logic                        miss_req_o,
  output logic [ADDR_SIZE-1:0]        miss_addr_o,
  input  logic                        refill_done_i,
  output logic                        instr_valid_o,
  output logic [WORD_SIZE-1:0]        instr_o,
  output logic [ADDR_SIZE-1:0]        pc_o,
  input  logic                        id_ready_i,
  input  logic                        redirect_i,
  input  logic [ADDR_SIZE-1:0]        redirect_pc_i,
  input  logic                        branch_done_i,
  output logic [$clog2(FQ_DEPTH):0]   fq_count_o
);
  localparam int unsigned EW = ADDR_SIZE + WORD_SIZE;

  if_fq_state_e         state;
  logic [ADDR_SIZE-1:0] fetch_pc;
  logic [EW-1:0]        head;
  logic                 full, empty, hit, miss, pop;

  assign ic_req_o      = state == IF_FQ_FETCH && !full && !redirect_i;
  assign ic_addr_o     = fetch_pc;
  assign miss          = ic_req_o && ic_miss_i;
  assign hit           = ic_req_o && ic_hit_i && !ic_miss_i;
  assign pop           = !empty && id_ready_i && !redirect_i;
  assign instr_valid_o = !empty;
  assign instr_o       = empty ? WORD_SIZE'(NOP) : head[WORD_SIZE-1:0];
  assign pc_o          = empty ? '0 : head[EW-1 -: ADDR_SIZE];

  segre_fetch_fifo #(.WIDTH(EW), .DEPTH(FQ_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (hit),
    .pop   (pop),
    .flush (redirect_i),
    .wdata ({fetch_pc, ic_data_i}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fq_count_o)
  );

  // a redirect taken during MISS only retargets fetch_pc; the refill still has to land
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state       <= IF_FQ_FETCH;
      fetch_pc    <= RESET_PC;
      miss_req_o  <= 1'b0;
      miss_addr_o <= '0;
    end else begin
      miss_req_o <= miss;
      if (redirect_i) begin
        fetch_pc <= redirect_pc_i & ~ADDR_SIZE'(3);
        if (state != IF_FQ_MISS || refill_done_i) state <= IF_FQ_FETCH;
      end else if (miss) begin
        miss_addr_o <= fetch_pc;
        state       <= IF_FQ_MISS;
      end else if (hit) begin
        fetch_pc <= fetch_pc + ADDR_SIZE'(4);
        if (BRANCH_STALL && is_cf(ic_data_i[6:0])) state <= IF_FQ_BR_WAIT;
      end else if ((state == IF_FQ_MISS && refill_done_i) ||
                   (state == IF_FQ_BR_WAIT && branch_done_i))
        state <= IF_FQ_FETCH;
    end

endmodule
